// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline stage with flush and a saturating count of flushes that discarded valid entries.
// Only out_ctrl is masked for bubbles; the payload registers are never cleared.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               accept_s;
  logic               drain_s;

  assign in_ready  = (state_q != ST_FULL) & ~flush;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept_s  = in_valid & in_ready;
  assign drain_s   = out_valid & out_ready;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : {CTRL_W{1'b0}};
  assign occupancy = state_q;
  assign flush_cnt = flush_cnt_q;

  // Next-state and entry-register selection; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && !drain_s) begin
            state_d     = ST_FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (accept_s && drain_s) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (drain_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // The skid entry is younger, so it becomes the new head.
          if (drain_s) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of flushes that actually threw away held entries.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Control state and statistics; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Payload registers carry no reset; validity comes solely from state_q.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    main_ctrl_q <= main_ctrl_d;
    skid_data_q <= skid_data_d;
    skid_ctrl_q <= skid_ctrl_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random bench for pipe_stage_reg: a queue scoreboard holds every accepted beat
// and a small occupancy/flush-count model predicts the handshake outputs.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  flush_cnt;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  beat_t sb_q[$];
  int    m_occ;
  int    m_cnt;
  int    checks;
  int    failures;
  bit    checking;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .flush_cnt (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, update the model, then advance one clock.
  task automatic tick();
    bit    exp_ready;
    bit    acc;
    bit    drn;
    beat_t head;
    #1;
    exp_ready = (m_occ != 2) && !flush;
    acc = in_valid && exp_ready;
    drn = (m_occ != 0) && out_ready;
    if (checking) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(m_occ != 0));
      chk("occupancy", 64'(occupancy), 64'(m_occ));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_cnt));
      if (m_occ != 0) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", 64'(sb_q.size()), 64'd1);
        end else begin
          head = sb_q[0];
          chk("out_data", 64'(out_data), 64'(head.d));
          chk("out_ctrl", 64'(out_ctrl), 64'(head.c));
        end
      end else begin
        chk("out_ctrl_mask", 64'(out_ctrl), 64'd0);
      end
    end
    if (drn && sb_q.size() != 0) void'(sb_q.pop_front());
    if (acc) sb_q.push_back({in_data, in_ctrl});
    if (rst) begin
      sb_q.delete();
      m_occ = 0;
      m_cnt = 0;
    end else if (flush) begin
      if (m_occ != 0 && m_cnt != 3) m_cnt++;
      sb_q.delete();
      m_occ = 0;
    end else begin
      m_occ = m_occ + int'(acc) - int'(drn);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    checking = 1'b0;
    m_occ = 0;
    m_cnt = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 32'd0;
    in_ctrl = 16'd0;

    // Reset
    tick();
    checking = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_occ", 64'(occupancy), 64'd0);

    // Streaming
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_data = 32'(i);
      in_ctrl = 16'(i * 3);
      tick();
    end
    chk("stream_occ", 64'(occupancy), 64'd1);
    chk("stream_data", 64'(out_data), 64'd6);
    in_valid = 1'b0;
    tick();

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA;
    in_ctrl = 16'h0A0A;
    tick();
    in_data = 32'hB;
    in_ctrl = 16'h0B0B;
    tick();
    in_data = 32'hC;
    tick();
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_head", 64'(out_data), 64'hA);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    chk("bp_second", 64'(out_data), 64'hB);
    tick();
    chk("bp_empty", 64'(occupancy), 64'd0);

    // Flush from FULL, then flush while EMPTY
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 16'h00FF;
    in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_cnt1", 64'(flush_cnt), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_empty_cnt", 64'(flush_cnt), 64'd1);

    // Flush, accept and drain together while ONE
    in_valid = 1'b1;
    in_data = 32'h55;
    in_ctrl = 16'h0055;
    tick();
    flush = 1'b1;
    out_ready = 1'b1;
    in_data = 32'h66;
    in_ctrl = 16'h0066;
    #1;
    chk("simul_in_ready", 64'(in_ready), 64'd0);
    chk("simul_head", 64'(out_data), 64'h55);
    tick();
    flush = 1'b0;
    chk("simul_occ", 64'(occupancy), 64'd0);
    tick();
    chk("simul_replay", 64'(out_data), 64'h66);
    in_valid = 1'b0;
    tick();

    // Saturation: three more effective flushes bring the total to five
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = 32'(k + 32'h100);
      tick();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    tick();
    chk("sat_cnt", 64'(flush_cnt), 64'd3);

    // Reset while FULL
    in_valid = 1'b1;
    in_data = 32'h77;
    tick();
    in_data = 32'h88;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_cnt", 64'(flush_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      in_data = 32'(1000 + n);
      in_ctrl = 16'($urandom);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the payload data (pc, operands, immediates).
REQ-002 SHALL have parameter CTRL_W, default 16: width of the control field (reg_write, mem_write, jal, ...), zeroed on bubbles.
REQ-003 SHALL have parameter CNT_W, default 16: width of the flush statistics counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush  input  1  discard all held entries (branch/jump redirect).
REQ-007 SHALL have port in_valid  input  1  upstream beat present.
REQ-008 SHALL have port in_ready  output  1  stage can accept a beat this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 SHALL have port out_valid  output  1  downstream beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-013 SHALL have port out_data  output  DATA_W  head payload.
REQ-014 SHALL have port out_ctrl  output  CTRL_W  head control bits, all zero when out_valid=0.
REQ-015 SHALL have port occupancy  output  2  number of held entries (0..2).
REQ-016 SHALL have port flush_cnt  output  CNT_W  count of flushes that discarded at least one valid entry.

Function
REQ-017 SHALL hold at most two entries, a main register (head) and a skid register, giving a 2-entry skid buffer.
REQ-018 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready.
REQ-019 SHALL drive in_ready = (occupancy != 2) & ~flush; this is the only combinational input-to-output path besides the out_ctrl mask.
REQ-020 SHALL drive out_valid = (occupancy != 0) and out_data/out_ctrl from the main register; out_ctrl is masked to 0 when out_valid=0.
REQ-021 SHALL implement the EMPTY (occ 0), ONE (occ 1) and FULL (occ 2) states.
REQ-022 EMPTY: accept -> ONE with the beat in main.
REQ-023 ONE: accept & ~drain -> FULL with the beat in skid; accept & drain -> ONE with the beat in main; ~accept & drain -> EMPTY; otherwise hold.
REQ-024 FULL: drain -> ONE with skid copied to main; otherwise hold. No accept is possible in FULL.
REQ-025 SHALL give a latency of 1 cycle: a beat accepted in cycle N into an empty stage is presented with out_valid=1 in cycle N+1.
REQ-026 SHALL sustain a throughput of 1 beat/cycle while out_ready=1.
REQ-027 SHALL deliver beats in order, with no loss or duplication, under any out_ready pattern.
REQ-028 SHALL keep out_data/out_ctrl stable while out_valid=1 and out_ready=0.
REQ-029 flush SHALL have priority over accept and drain: the next state is EMPTY, and the beat presented upstream in the flush cycle is not accepted (in_ready=0).
REQ-030 A beat shown on out in a flush cycle with out_ready=1 SHALL count as consumed by downstream; the stage itself still goes EMPTY.
REQ-031 SHALL increment flush_cnt by 1 when flush=1 and occupancy!=0, saturating at 2^CNT_W-1 with no wrap.
REQ-032 Data registers SHALL NOT need clearing on flush or reset; only the valid state and the masking define bubbles.

Reset
REQ-033 While rst=1 at a rising edge, SHALL set state EMPTY, occupancy=0, out_valid=0, out_ctrl=0 and flush_cnt=0.
REQ-034 After reset, in_ready SHALL read 1 (with flush=0); out_data is unspecified.
REQ-035 rst SHALL have priority over flush, accept and drain; held entries are discarded and flush_cnt is not incremented.

Verification
REQ-036 Streaming: in_valid=1 with data 1,2,3..., out_ready=1 -> out_data 1,2,3... one cycle later, occupancy stays 1, in_ready stays 1.
REQ-037 Backpressure: out_ready=0 and two beats 0xA, 0xB accepted -> occupancy=2, in_ready=0, out_data=0xA stable; out_ready=1 for two cycles -> 0xA then 0xB, occupancy 0.
REQ-038 Flush: FULL with ctrl=0x00FF, flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, flush_cnt=1; a flush while EMPTY leaves flush_cnt=1.
REQ-039 Simultaneous events: flush=1, in_valid=1, out_ready=1 in ONE -> in_ready=0, head beat consumed, next state EMPTY, upstream beat still presented next cycle.
REQ-040 Saturation: CNT_W=2 with 5 effective flushes -> flush_cnt=3.
REQ-041 Reset mid-operation: rst=1 in FULL -> next cycle occupancy=0, out_valid=0, flush_cnt=0, in_ready=1.
